// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller arbitrating instruction fetch and
// load/store ports onto an 8-bit little-endian external memory bus.
module mem_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int IF_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_ack,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    LS_RD,
    LS_WR,
    IF_RD,
    DONE
  } state_t;

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [2:0]        len_q, len_n;
  logic [2:0]        cnt_q, cnt_n;
  logic              fetch_q, fetch_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [31:0]       rbuf_q, rbuf_n;
  logic [ADDR_W-1:0] a_q, a_n;
  logic [7:0]        dout_q, dout_n;
  logic              wr_q, wr_n;
  logic [31:0]       if_data_n;
  logic [31:0]       ls_rdata_n;

  logic [1:0]        rd_bi;
  logic [1:0]        wr_bi;
  logic              more;
  logic [ADDR_W-1:0] next_a;
  logic [2:0]        ls_len;

  assign rd_bi  = 2'(cnt_q - 3'd1);
  assign wr_bi  = 2'(cnt_q + 3'd1);
  assign more   = (cnt_q + 3'd1) < len_q;
  assign next_a = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);

  always_comb begin
    ls_len = 3'd4;
    if (ls_size == 2'b00) ls_len = 3'd1;
    else if (ls_size == 2'b01) ls_len = 3'd2;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      fetch_q  <= 1'b0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      a_q      <= '0;
      dout_q   <= '0;
      wr_q     <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
    end else if (rdy) begin
      state_q  <= state_n;
      addr_q   <= addr_n;
      len_q    <= len_n;
      cnt_q    <= cnt_n;
      fetch_q  <= fetch_n;
      wdata_q  <= wdata_n;
      rbuf_q   <= rbuf_n;
      a_q      <= a_n;
      dout_q   <= dout_n;
      wr_q     <= wr_n;
      if_data  <= if_data_n;
      ls_rdata <= ls_rdata_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    addr_n     = addr_q;
    len_n      = len_q;
    cnt_n      = cnt_q;
    fetch_n    = fetch_q;
    wdata_n    = wdata_q;
    rbuf_n     = rbuf_q;
    a_n        = '0;
    dout_n     = '0;
    wr_n       = 1'b0;
    if_data_n  = if_data;
    ls_rdata_n = ls_rdata;
    unique case (state_q)
      IDLE: begin
        if (ls_req) begin
          addr_n  = ls_addr;
          len_n   = ls_len;
          cnt_n   = '0;
          fetch_n = 1'b0;
          wdata_n = ls_wdata;
          rbuf_n  = '0;
          a_n     = ls_addr;
          if (ls_wr) begin
            state_n = LS_WR;
            dout_n  = ls_wdata[7:0];
            wr_n    = 1'b1;
          end else begin
            state_n = LS_RD;
          end
        end else if (if_req && !if_flush) begin
          addr_n  = if_addr;
          len_n   = 3'(IF_BYTES);
          cnt_n   = '0;
          fetch_n = 1'b1;
          rbuf_n  = '0;
          a_n     = if_addr;
          state_n = IF_RD;
        end
      end
      LS_RD, IF_RD: begin
        if (state_q == IF_RD && if_flush) begin
          state_n = IDLE;
        end else begin
          // byte k-1 arrives the cycle after its address
          if (cnt_q != 3'd0) rbuf_n[{rd_bi, 3'b000} +: 8] = mem_din;
          if (cnt_q == len_q) begin
            state_n = DONE;
            if (fetch_q) if_data_n = rbuf_n;
            else ls_rdata_n = rbuf_n;
          end else begin
            cnt_n = cnt_q + 3'd1;
            if (more) a_n = next_a;
          end
        end
      end
      LS_WR: begin
        if (more) begin
          cnt_n  = cnt_q + 3'd1;
          a_n    = next_a;
          dout_n = wdata_q[{wr_bi, 3'b000} +: 8];
          wr_n   = 1'b1;
        end else begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign if_ack   = (state_q == DONE) && fetch_q;
  assign ls_ack   = (state_q == DONE) && !fetch_q;
  assign busy     = (state_q != IDLE);
  assign mem_a    = a_q;
  assign mem_dout = dout_q;
  assign mem_wr   = wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a
// byte-addressed reference memory and per-access timing rules.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ack;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [0:131071];
  logic [7:0]  refm [logic [31:0]];
  logic [31:0] rlog [$];
  logic [39:0] wlog [$];

  mem_ctrl #(.ADDR_W(32), .IF_BYTES(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external RAM: one-cycle read latency, frozen while rdy is low
  always @(posedge clk) begin
    if (rdy) mem_din <= mem[mem_a[16:0]];
    if (mem_wr) begin
      mem[mem_a[16:0]] <= mem_dout;
      wlog.push_back({mem_a, mem_dout});
    end
    if (rst && rdy && !mem_wr && mem_a != 32'h0) rlog.push_back(mem_a);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [7:0] rget(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : 8'h00;
  endfunction

  task automatic ls_op(input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int st_at, input int st_len);
    int n;
    int t;
    int lat;
    logic got;
    logic [31:0] exp;
    n = nbytes(sz);
    lat = (wr ? n + 1 : n + 2) + st_len;
    rlog.delete();
    wlog.delete();
    ls_wr = wr;
    ls_size = sz;
    ls_addr = a;
    ls_wdata = wd;
    ls_req = 1'b1;
    t = 0;
    got = 1'b0;
    while (!got && t < 40) begin
      tick();
      t++;
      if (ls_ack) begin
        got = 1'b1;
      end else if (st_len > 0 && t == st_at) begin
        rdy = 1'b0;
        for (int k = 0; k < st_len; k++) begin
          tick();
          t++;
          check("stall_mem_wr", 64'(mem_wr), 64'd0);
        end
        rdy = 1'b1;
      end
    end
    ls_req = 1'b0;
    check("ls_ack_seen", 64'(got), 64'd1);
    check("ls_ack_latency", 64'(t), 64'(lat));
    if (wr) begin
      check("wr_count", 64'(wlog.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
        refm[a + 32'(i)] = wd[8*i +: 8];
        if (i < wlog.size())
          check("wr_byte", 64'(wlog[i]), 64'({a + 32'(i), wd[8*i +: 8]}));
      end
    end else begin
      exp = '0;
      for (int i = 0; i < n; i++) exp[8*i +: 8] = rget(a + 32'(i));
      check("ls_rdata", 64'(ls_rdata), 64'(exp));
      check("rd_count", 64'(rlog.size()), 64'(n));
    end
    tick();
    check("ls_ack_pulse", 64'({ls_ack, busy}), 64'd0);
  endtask

  task automatic if_op(input logic [31:0] a);
    int t;
    logic got;
    logic [31:0] exp;
    rlog.delete();
    if_addr = a;
    if_req = 1'b1;
    t = 0;
    got = 1'b0;
    while (!got && t < 40) begin
      tick();
      t++;
      if (t <= 4) check("if_mem_a", 64'(mem_a), 64'(a + 32'(t - 1)));
      if (if_ack) got = 1'b1;
    end
    if_req = 1'b0;
    check("if_ack_latency", 64'(t), 64'd6);
    exp = {rget(a + 32'd3), rget(a + 32'd2), rget(a + 32'd1), rget(a)};
    check("if_data", 64'(if_data), 64'(exp));
    check("if_rd_count", 64'(rlog.size()), 64'd4);
    tick();
    check("if_ack_pulse", 64'({if_ack, busy}), 64'd0);
  endtask

  initial begin
    int t;
    int t2;
    logic seen;
    logic [31:0] ra;
    logic [1:0] rs;
    int op;
    int st;

    rst = 1'b0;
    rdy = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    if_flush = 1'b0;
    ls_req = 1'b0;
    ls_wr = 1'b0;
    ls_size = '0;
    ls_addr = '0;
    ls_wdata = '0;
    repeat (3) tick();
    check("rst_data", 64'({if_data, ls_rdata}), 64'd0);
    check("rst_bus", 64'({mem_a, mem_dout, mem_wr}), 64'd0);
    check("rst_ctl", 64'({if_ack, ls_ack, busy}), 64'd0);
    rst = 1'b1;
    tick();

    // word fetch of 13,00,00,93
    ls_op(1'b1, 2'b10, 32'h100, 32'h9300_0013, 0, 0);
    if_op(32'h100);
    check("fetch_word", 64'(if_data), 64'h9300_0013);

    // contention: load wins, fetch follows after DONE
    ls_op(1'b1, 2'b10, 32'h200, 32'hDEAD_BEEF, 0, 0);
    if_addr = 32'h100;
    if_req = 1'b1;
    ls_wr = 1'b0;
    ls_size = 2'b10;
    ls_addr = 32'h200;
    ls_req = 1'b1;
    t = 0;
    seen = 1'b0;
    while (!ls_ack && t < 40) begin
      tick();
      t++;
      if (if_ack) seen = 1'b1;
    end
    ls_req = 1'b0;
    check("cont_ls_latency", 64'(t), 64'd6);
    check("cont_ls_rdata", 64'(ls_rdata), 64'hDEAD_BEEF);
    check("cont_no_early_if", 64'(seen), 64'd0);
    t2 = 0;
    while (!if_ack && t2 < 40) begin
      tick();
      t2++;
    end
    if_req = 1'b0;
    check("cont_if_latency", 64'(t2), 64'd7);
    check("cont_if_data", 64'(if_data), 64'h9300_0013);
    tick();

    // store half to I/O, then a single-read byte load
    ls_op(1'b1, 2'b01, 32'h3_0000, 32'h1234_5678, 0, 0);
    ls_op(1'b0, 2'b00, 32'h3_0000, 32'h0, 0, 0);
    check("io_byte", 64'(ls_rdata), 64'h78);

    // flush mid fetch
    ls_op(1'b1, 2'b10, 32'h80, 32'h00A0_0093, 0, 0);
    rlog.delete();
    if_addr = 32'h40;
    if_req = 1'b1;
    tick();
    tick();
    if_flush = 1'b1;
    if_req = 1'b0;
    tick();
    if_flush = 1'b0;
    check("flush_idle", 64'({busy, mem_a}), 64'd0);
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (if_ack) seen = 1'b1;
    end
    check("flush_no_ack", 64'(seen), 64'd0);
    check("flush_addrs", 64'(rlog.size() <= 2), 64'd1);
    if_op(32'h80);

    // three-cycle stall in the middle of a word store
    ls_op(1'b1, 2'b10, 32'h500, 32'hCAFE_F00D, 2, 3);
    ls_op(1'b0, 2'b10, 32'h500, 32'h0, 0, 0);

    // reset during a word load
    ls_wr = 1'b0;
    ls_size = 2'b10;
    ls_addr = 32'h200;
    ls_req = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    ls_req = 1'b0;
    tick();
    check("mid_rst_data", 64'({if_data, ls_rdata}), 64'd0);
    check("mid_rst_bus", 64'({mem_a, mem_dout, mem_wr}), 64'd0);
    check("mid_rst_ctl", 64'({if_ack, ls_ack, busy}), 64'd0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (ls_ack) seen = 1'b1;
    end
    check("mid_rst_no_ack", 64'(seen), 64'd0);
    ls_op(1'b0, 2'b10, 32'h200, 32'h0, 0, 0);
    check("post_rst_load", 64'(ls_rdata), 64'hDEAD_BEEF);

    // address wrap
    ls_op(1'b1, 2'b10, 32'hFFFF_FFFE, 32'h4433_2211, 0, 0);
    ls_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0, 0, 0);
    check("wrap_hi", 64'(ls_rdata), 64'h22);
    ls_op(1'b0, 2'b00, 32'h1, 32'h0, 0, 0);
    check("wrap_lo", 64'(ls_rdata), 64'h44);

    // randomized traffic over a prefilled region
    for (int i = 0; i < 17; i++)
      ls_op(1'b1, 2'b10, 32'h1000 + 32'(4 * i), $urandom, 0, 0);
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      ra = 32'h1000 + 32'($urandom_range(0, 60));
      rs = 2'($urandom_range(0, 3));
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      if (op == 0) ls_op(1'b1, rs, ra, $urandom, 1, st);
      else if (op == 1) ls_op(1'b0, rs, ra, 32'h0, 1, st);
      else if_op(ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the CPU-side cache/fetch and load/store units and the 8-bit external memory bus.
- Arbitrates one instruction-fetch port (4-byte reads) and one load/store port (1/2/4-byte reads and writes).
- Sequences each access into per-byte bus cycles, honouring the 2-cycle read / 1-cycle write timing of the RAM and I/O space.
- Little-endian assembly and disassembly of words.

Parameters:
ADDR_W, 32, address width of request ports and bus
IF_BYTES, 4, bytes per instruction fetch

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
rdy  in  1  global ready; low freezes the block
if_req  in  1  fetch request, level, held stable until if_ack
if_addr  in  32  fetch byte address
if_flush  in  1  abort pending/in-flight fetch (branch redirect)
if_ack  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word
ls_req  in  1  load/store request, level, held stable until ls_ack
ls_wr  in  1  1 = store, 0 = load
ls_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
ls_addr  in  32  byte address
ls_wdata  in  32  store data, low bytes used
ls_ack  out  1  one-cycle pulse, access complete
ls_rdata  out  32  load data, zero-extended; sign extension is done by the requester
mem_din  in  8  memory read byte
mem_dout  out  8  memory write byte
mem_a  out  32  memory byte address
mem_wr  out  1  1 = write
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=0 at edge): state IDLE; all outputs 0, including mem_a, mem_dout, mem_wr, if_ack, ls_ack, if_data, ls_rdata and busy.
- Reset mid-transaction abandons it; no ack is issued.
- rdy=0: every register holds. mem_wr is gated to 0 combinationally. mem_din is guaranteed stable by the environment across the stall.
- States:
  - IDLE: if ls_req, go to LS_RD or LS_WR. Else if if_req && !if_flush, go to IF_RD. Load/store has strict priority.
  - LS_RD / IF_RD / LS_WR: sequence the bytes of the access.
  - DONE: ack high for exactly one cycle, then IDLE.
  - No request is accepted in DONE, so a still-high req during ack is never re-accepted.
- N = byte count: 1/2/4 for ls_size, IF_BYTES for fetch. Byte addresses are addr+i, 32-bit wrapping add; no alignment check.
- Read timing (request accepted in cycle T):
  - mem_a = addr+i in cycle T+1+i, i = 0..N-1.
  - Byte i is sampled from mem_din at the end of cycle T+2+i into bits [8i+7:8i].
  - Ack is in cycle T+N+2; word fetch ack is in T+6.
  - mem_wr = 0 throughout.
  - Unused upper ls_rdata bytes are 0.
- Write timing:
  - mem_a = addr+i, mem_dout = ls_wdata[8i+7:8i], mem_wr = 1 in cycle T+1+i.
  - ls_ack in cycle T+N+1, with mem_wr = 0, mem_a = 0 and mem_dout = 0 in that cycle.
- Reads never exceed N bytes and are never speculative. Required for I/O: a byte load from 0x30000 issues exactly one bus read.
- if_data / ls_rdata hold their last value until the next ack of the same port.
- if_flush:
  - In IF_RD, return to IDLE next cycle with no if_ack; mem_a = 0.
  - In IDLE, it blocks fetch acceptance that cycle; a simultaneous ls_req is still accepted.
  - Ignored during LS states.
  - In DONE for a fetch, if_ack still pulses; the fetch unit discards it.
- In-flight fetches are never pre-empted by ls_req; the load/store waits for DONE→IDLE.
- busy = (state != IDLE).

Test Plan:
- Word fetch: if_req=1, if_addr=0x100, memory bytes 13,00,00,93 → mem_a 0x100..0x103 in T+1..T+4; if_ack in T+6 with if_data=0x93000013.
- Contention: if_req and ls_req (load word @0x200 = 0xDEADBEEF) in the same cycle → load is served first, ls_ack ls_rdata=0xDEADBEEF; then fetch starts the cycle after DONE.
- Store half: ls_wr=1, size=01, addr=0x30000, wdata=0x1234_5678 → mem_wr=1 with (0x30000,0x78) and (0x30001,0x56); ls_ack in T+3; exactly two write cycles.
- Flush: fetch @0x40 with if_flush=1 in T+2 → IDLE at T+3, no if_ack, at most 2 addresses issued; a subsequent fetch @0x80 completes normally.
- Stall: rdy=0 for 3 cycles mid word store → mem_wr=0 during the stall, each of the 4 bytes written exactly once, ls_ack delayed by 3 cycles.
- Reset: rst=0 during a word load → all outputs 0 next cycle, no ls_ack; a new load after release completes with correct data.
